// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data-SRAM responses, extracts load data,
// and drops responses that belong to instructions killed by a WB flush.
module mem_stage #(
    parameter int unsigned SB_WD = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             es_to_ms_valid,
    output logic             ms_allowin,
    input  logic [31:0]      es_pc,
    input  logic [31:0]      es_result,
    input  logic [4:0]       es_dest,
    input  logic             es_gr_we,
    input  logic [2:0]       es_ld_op,
    input  logic             es_mem_req,
    input  logic             es_ex,
    input  logic [SB_WD-1:0] es_sideband,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata,
    input  logic             ws_allowin,
    input  logic             ws_flush_pipe,
    output logic             ms_to_ws_valid,
    output logic [31:0]      ms_pc,
    output logic [31:0]      ms_final_result,
    output logic [4:0]       ms_dest,
    output logic             ms_gr_we,
    output logic             ms_ex,
    output logic [SB_WD-1:0] ms_sideband,
    output logic             ms_fwd_valid,
    output logic [4:0]       ms_fwd_dest,
    output logic [31:0]      ms_fwd_data,
    output logic             ms_fwd_block,
    output logic             ms_ex_block
);

    logic             r_ms_valid;
    logic [31:0]      r_pc;
    logic [31:0]      r_result;
    logic [4:0]       r_dest;
    logic             r_gr_we;
    logic [2:0]       r_ld_op;
    logic             r_ex;
    logic [SB_WD-1:0] r_sideband;
    logic [1:0]       r_addr_lo;
    logic             r_req;
    logic             r_got;
    logic [31:0]      r_rdata;
    logic [1:0]       r_drop_cnt;

    logic        w_drop_zero;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_capture;
    logic        w_drain;
    logic        w_pend;
    logic        w_new_req;
    logic [2:0]  w_drop_next;
    logic [31:0] w_ld_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_ext;

    assign w_drop_zero = (r_drop_cnt == 2'd0);
    assign w_ready_go  = !r_req || r_got || (data_sram_data_ok && w_drop_zero);
    assign ms_allowin  = !r_ms_valid || (w_ready_go && ws_allowin);
    assign w_accept    = es_to_ms_valid && ms_allowin && !ws_flush_pipe;
    assign w_capture   = data_sram_data_ok && w_drop_zero && r_ms_valid && r_req && !r_got;
    assign w_drain     = data_sram_data_ok && !w_drop_zero;

    // Requests in flight that will never be consumed once the flush kills their owners.
    assign w_pend    = r_ms_valid && r_req && !r_got && !(data_sram_data_ok && w_drop_zero);
    assign w_new_req = es_to_ms_valid && es_mem_req;

    always_comb begin
        w_drop_next = {1'b0, r_drop_cnt};
        if (ws_flush_pipe) begin
            w_drop_next = w_drop_next + {2'b00, w_pend} + {2'b00, w_new_req};
        end
        if (w_drain) begin
            w_drop_next = w_drop_next - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (ws_flush_pipe) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc       <= es_pc;
            r_result   <= es_result;
            r_dest     <= es_dest;
            r_gr_we    <= es_gr_we;
            r_ld_op    <= es_ld_op;
            r_ex       <= es_ex;
            r_sideband <= es_sideband;
            r_addr_lo  <= es_result[1:0];
            r_req      <= es_mem_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_got      <= 1'b0;
            r_drop_cnt <= 2'd0;
        end else begin
            r_drop_cnt <= w_drop_next[1:0];
            if (w_accept) begin
                r_got <= 1'b0;
            end else if (w_capture) begin
                r_got <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_rdata <= data_sram_rdata;
        end
    end

    assign w_ld_word = r_got ? r_rdata : data_sram_rdata;
    assign w_half    = r_addr_lo[1] ? w_ld_word[31:16] : w_ld_word[15:0];

    always_comb begin
        w_byte = w_ld_word[7:0];
        case (r_addr_lo)
            2'd1:    w_byte = w_ld_word[15:8];
            2'd2:    w_byte = w_ld_word[23:16];
            2'd3:    w_byte = w_ld_word[31:24];
            default: w_byte = w_ld_word[7:0];
        endcase
    end

    always_comb begin
        w_ld_ext = w_ld_word;
        case (r_ld_op)
            3'd1:    w_ld_ext = {{24{w_byte[7]}}, w_byte};
            3'd2:    w_ld_ext = {{16{w_half[15]}}, w_half};
            3'd4:    w_ld_ext = {24'h0, w_byte};
            3'd5:    w_ld_ext = {16'h0, w_half};
            default: w_ld_ext = w_ld_word;
        endcase
    end

    assign ms_to_ws_valid  = r_ms_valid && w_ready_go;
    assign ms_pc           = r_pc;
    assign ms_final_result = (r_ld_op != 3'd0) ? w_ld_ext : r_result;
    assign ms_dest         = r_dest;
    assign ms_gr_we        = r_gr_we;
    assign ms_ex           = r_ex;
    assign ms_sideband     = r_sideband;
    assign ms_fwd_valid    = r_ms_valid && r_gr_we;
    assign ms_fwd_dest     = r_dest;
    assign ms_fwd_data     = ms_final_result;
    assign ms_fwd_block    = r_ms_valid && (r_ld_op != 3'd0) && !w_ready_go;
    assign ms_ex_block     = r_ms_valid && r_ex;

    // At most one killed MS request plus one killed EXE request can be pending.
    a_drop_cnt_max: assert property (@(posedge clk) disable iff (reset) w_drop_next <= 3'd2);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table-driven load/ALU vectors plus multi-cycle
// sequences for response latency, flush draining, WB stall and reset.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         es_to_ms_valid;
    logic         ms_allowin;
    logic [31:0]  es_pc;
    logic [31:0]  es_result;
    logic [4:0]   es_dest;
    logic         es_gr_we;
    logic [2:0]   es_ld_op;
    logic         es_mem_req;
    logic         es_ex;
    logic [127:0] es_sideband;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_allowin;
    logic         ws_flush_pipe;
    logic         ms_to_ws_valid;
    logic [31:0]  ms_pc;
    logic [31:0]  ms_final_result;
    logic [4:0]   ms_dest;
    logic         ms_gr_we;
    logic         ms_ex;
    logic [127:0] ms_sideband;
    logic         ms_fwd_valid;
    logic [4:0]   ms_fwd_dest;
    logic [31:0]  ms_fwd_data;
    logic         ms_fwd_block;
    logic         ms_ex_block;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.SB_WD(128)) dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_result         (es_result),
        .es_dest           (es_dest),
        .es_gr_we          (es_gr_we),
        .es_ld_op          (es_ld_op),
        .es_mem_req        (es_mem_req),
        .es_ex             (es_ex),
        .es_sideband       (es_sideband),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ws_flush_pipe     (ws_flush_pipe),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_final_result   (ms_final_result),
        .ms_dest           (ms_dest),
        .ms_gr_we          (ms_gr_we),
        .ms_ex             (ms_ex),
        .ms_sideband       (ms_sideband),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_fwd_dest       (ms_fwd_dest),
        .ms_fwd_data       (ms_fwd_data),
        .ms_fwd_block      (ms_fwd_block),
        .ms_ex_block       (ms_ex_block)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ld_op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid    = 1'b0;
        es_mem_req        = 1'b0;
        es_ex             = 1'b0;
        es_ld_op          = 3'd0;
        data_sram_data_ok = 1'b0;
        ws_allowin        = 1'b1;
        ws_flush_pipe     = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                         input logic [2:0] ld_op, input logic mem_req, input logic ex);
        es_to_ms_valid = 1'b1;
        es_pc          = pc;
        es_result      = res;
        es_dest        = dest;
        es_gr_we       = 1'b1;
        es_ld_op       = ld_op;
        es_mem_req     = mem_req;
        es_ex          = ex;
        es_sideband    = {pc, res, 27'h0, dest, 32'h5A5A_0000};
    endtask

    initial begin
        es_pc           = 32'h0;
        es_result       = 32'h0;
        es_dest         = 5'd0;
        es_gr_we        = 1'b0;
        es_sideband     = '0;
        data_sram_rdata = 32'h0;
        idle();

        vecs[0] = '{3'd1, 32'h0000_2003, 32'h8011_2233, 32'hFFFF_FF80};
        vecs[1] = '{3'd4, 32'h0000_2003, 32'h8011_2233, 32'h0000_0080};
        vecs[2] = '{3'd5, 32'h0000_2002, 32'h8011_2233, 32'h0000_8011};
        vecs[3] = '{3'd2, 32'h0000_2002, 32'h8011_2233, 32'hFFFF_8011};
        vecs[4] = '{3'd1, 32'h0000_2000, 32'h8011_2233, 32'h0000_0033};
        vecs[5] = '{3'd4, 32'h0000_2001, 32'h8011_2233, 32'h0000_0022};
        vecs[6] = '{3'd2, 32'h0000_2000, 32'h1234_F678, 32'hFFFF_F678};
        vecs[7] = '{3'd3, 32'h0000_2004, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[8] = '{3'd0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
        vecs[9] = '{3'd1, 32'h0000_2002, 32'h8011_2233, 32'h0000_0011};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
        check("rst_allowin", ms_allowin, 1'b1);
        check("rst_fwd_valid", ms_fwd_valid, 1'b0);
        check("rst_fwd_block", ms_fwd_block, 1'b0);
        check("rst_ex_block", ms_ex_block, 1'b0);

        // Table: each load gets its response in its first MS cycle.
        for (int i = 0; i < 10; i++) begin
            issue(32'h1C00_0000 + 32'(i * 4), vecs[i].addr, 5'(i + 1), vecs[i].ld_op,
                  vecs[i].ld_op != 3'd0, 1'b0);
            tick();
            es_to_ms_valid    = 1'b0;
            es_mem_req        = 1'b0;
            data_sram_data_ok = (vecs[i].ld_op != 3'd0);
            data_sram_rdata   = vecs[i].rdata;
            settle();
            check($sformatf("vec%0d_valid", i), ms_to_ws_valid, 1'b1);
            check($sformatf("vec%0d_result", i), ms_final_result, vecs[i].exp);
            check($sformatf("vec%0d_fwd_data", i), ms_fwd_data, vecs[i].exp);
            check($sformatf("vec%0d_dest", i), ms_dest, 5'(i + 1));
            check($sformatf("vec%0d_fwd_block", i), ms_fwd_block, 1'b0);
            tick();
            data_sram_data_ok = 1'b0;
        end

        // ld.w with the response arriving in the third MS cycle.
        issue(32'h1C00_0100, 32'h0000_1004, 5'd7, 3'd3, 1'b1, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        es_mem_req     = 1'b0;
        for (int c = 0; c < 2; c++) begin
            settle();
            check($sformatf("lat_wait%0d_valid", c), ms_to_ws_valid, 1'b0);
            check($sformatf("lat_wait%0d_fwd_block", c), ms_fwd_block, 1'b1);
            check($sformatf("lat_wait%0d_allowin", c), ms_allowin, 1'b0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8899_AABB;
        settle();
        check("lat_valid", ms_to_ws_valid, 1'b1);
        check("lat_result", ms_final_result, 32'h8899_AABB);
        check("lat_fwd_block", ms_fwd_block, 1'b0);
        check("lat_fwd_valid", ms_fwd_valid, 1'b1);
        check("lat_pc", ms_pc, 32'h1C00_0100);
        tick();
        data_sram_data_ok = 1'b0;

        // Back-to-back ALU ops, one per cycle.
        for (int k = 0; k < 4; k++) begin
            issue(32'h1C00_0200 + 32'(k * 4), 32'hA000_0000 + 32'(k), 5'(k + 10), 3'd0, 1'b0,
                  1'b0);
            tick();
            settle();
            check($sformatf("b2b%0d_valid", k), ms_to_ws_valid, 1'b1);
            check($sformatf("b2b%0d_allowin", k), ms_allowin, 1'b1);
            check($sformatf("b2b%0d_pc", k), ms_pc, 32'h1C00_0200 + 32'(k * 4));
            check($sformatf("b2b%0d_result", k), ms_final_result, 32'hA000_0000 + 32'(k));
        end
        idle();
        tick();
        check("b2b_drained", ms_to_ws_valid, 1'b0);

        // Flush with one load outstanding: exactly one response must be dropped.
        issue(32'h1C00_0300, 32'h0000_3000, 5'd3, 3'd3, 1'b1, 1'b0);
        tick();
        idle();
        ws_flush_pipe = 1'b1;
        tick();
        ws_flush_pipe = 1'b0;
        settle();
        check("fl1_killed", ms_to_ws_valid, 1'b0);
        issue(32'h1C00_0304, 32'h0000_3004, 5'd4, 3'd3, 1'b1, 1'b0);
        tick();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_0001;
        settle();
        check("fl1_drop_valid", ms_to_ws_valid, 1'b0);
        check("fl1_drop_block", ms_fwd_block, 1'b1);
        tick();
        data_sram_rdata = 32'h1111_2222;
        settle();
        check("fl1_new_valid", ms_to_ws_valid, 1'b1);
        check("fl1_new_result", ms_final_result, 32'h1111_2222);
        tick();
        idle();

        // Flush with a load in MS and a store in EXE: two responses dropped.
        issue(32'h1C00_0400, 32'h0000_4000, 5'd5, 3'd3, 1'b1, 1'b0);
        tick();
        issue(32'h1C00_0404, 32'h0000_4004, 5'd0, 3'd0, 1'b1, 1'b0);
        ws_flush_pipe = 1'b1;
        tick();
        ws_flush_pipe = 1'b0;
        issue(32'h1C00_0408, 32'h0000_4008, 5'd6, 3'd3, 1'b1, 1'b0);
        tick();
        idle();
        for (int d = 0; d < 2; d++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'hBAD0_0010 + 32'(d);
            settle();
            check($sformatf("fl2_drop%0d_valid", d), ms_to_ws_valid, 1'b0);
            check($sformatf("fl2_drop%0d_block", d), ms_fwd_block, 1'b1);
            tick();
        end
        data_sram_rdata = 32'h3333_4444;
        settle();
        check("fl2_new_valid", ms_to_ws_valid, 1'b1);
        check("fl2_new_result", ms_final_result, 32'h3333_4444);
        check("fl2_new_pc", ms_pc, 32'h1C00_0408);
        tick();
        idle();

        // WB stall while the response is present: captured data must hold.
        issue(32'h1C00_0500, 32'h0000_5000, 5'd8, 3'd3, 1'b1, 1'b0);
        tick();
        idle();
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        settle();
        check("stall_first_valid", ms_to_ws_valid, 1'b1);
        check("stall_first_result", ms_final_result, 32'hCAFE_F00D);
        check("stall_allowin", ms_allowin, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0000_0000;
        for (int s = 0; s < 2; s++) begin
            settle();
            check($sformatf("stall%0d_valid", s), ms_to_ws_valid, 1'b1);
            check($sformatf("stall%0d_result", s), ms_final_result, 32'hCAFE_F00D);
            tick();
        end
        ws_allowin = 1'b1;
        settle();
        check("stall_rel_result", ms_final_result, 32'hCAFE_F00D);
        check("stall_rel_allowin", ms_allowin, 1'b1);
        tick();
        check("stall_left", ms_to_ws_valid, 1'b0);

        // Excepting instruction: blocks EXE requests and carries sideband through.
        issue(32'h1C00_0600, 32'h0000_6000, 5'd9, 3'd0, 1'b0, 1'b1);
        tick();
        idle();
        settle();
        check("ex_block", ms_ex_block, 1'b1);
        check("ex_flag", ms_ex, 1'b1);
        check("ex_sideband", ms_sideband, {32'h1C00_0600, 32'h0000_6000, 27'h0, 5'd9,
                                           32'h5A5A_0000});
        tick();
        check("ex_block_clear", ms_ex_block, 1'b0);

        // Reset while a response is owed to a killed load clears the drop count.
        issue(32'h1C00_0700, 32'h0000_7000, 5'd2, 3'd3, 1'b1, 1'b0);
        tick();
        idle();
        ws_flush_pipe = 1'b1;
        tick();
        ws_flush_pipe = 1'b0;
        reset         = 1'b1;
        tick();
        reset = 1'b0;
        issue(32'h1C00_0704, 32'h0000_7006, 5'd2, 3'd5, 1'b1, 1'b0);
        tick();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_1234;
        settle();
        check("rst_mid_valid", ms_to_ws_valid, 1'b1);
        check("rst_mid_result", ms_final_result, 32'h0000_BEEF);
        tick();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, required finish within 200000ns");
        $fatal(1);
    end

endmodule
